// File: rtl/uart_rx_ctrl_if.sv
// Host-side read port of the Rx byte FIFO: show-ahead head entry, accept strobe and occupancy.
interface uart_rx_ctrl_if #(
    parameter int AW = 3
);
    logic          Valid_o;
    logic [7:0]    Data_o;
    logic          Err_o;
    logic          Marker_o;
    logic          Ready_i;
    logic [AW:0]   Count_o;

    modport master (
        output Valid_o, Data_o, Err_o, Marker_o, Count_o,
        input  Ready_i
    );

    modport slave (
        input  Valid_o, Data_o, Err_o, Marker_o, Count_o,
        output Ready_i
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART Rx sequencing controller: enables the Rx core, restarts it on a watchdog stall,
// and buffers received bytes plus frame-end markers in a show-ahead FIFO.
module uart_rx_ctrl #(
    parameter int DEPTH     = 8,
    parameter int AW        = 3,
    parameter int WDT_TICKS = 240,
    parameter int GAP_TICKS = 48,
    parameter int RCV_CYC   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         p_Enable_i,
    input  logic         AcqSig_i,
    input  logic [4:0]   RxState_i,
    input  logic         ByteValid_i,
    input  logic [7:0]   ByteData_i,
    input  logic         ParityErr_i,
    input  logic         StopErr_i,
    output logic         RxCoreEnable_o,
    output logic         RxCoreRst_o,
    uart_rx_ctrl_if.master host,
    output logic         Overflow_o,
    input  logic         OverflowClr_i,
    output logic         WdtEvent_o
);

    localparam int WW = $clog2(WDT_TICKS + 1);
    localparam int GW = $clog2(GAP_TICKS + 1);
    localparam int RW = $clog2(RCV_CYC + 1);
    localparam logic [4:0]    ST_INTERVAL = 5'b00001;
    localparam logic [AW-1:0] PTR_ONE     = AW'(1);
    localparam logic [AW:0]   CNT_ONE     = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL    = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_RECEIVING,
        S_RECOVER
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [WW-1:0]   r_wdt_cnt;
    logic [GW-1:0]   r_gap_cnt;
    logic [RW-1:0]   r_rcv_cnt;
    logic            r_wdt_evt;
    logic            r_byte_since_marker;

    logic            w_interval;
    logic            w_onehot;
    logic            w_wdt_hit;
    logic            w_gap_hit;
    logic            w_byte_push;
    logic            w_mark_push;
    logic            w_push;
    logic [9:0]      w_push_entry;

    logic [9:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            r_overflow;
    logic            w_valid;
    logic            w_full;
    logic            w_pop;
    logic            w_wr;

    assign w_interval = (RxState_i == ST_INTERVAL);
    assign w_onehot   = (RxState_i != 5'd0) && ((RxState_i & (RxState_i - 5'd1)) == 5'd0);
    assign w_wdt_hit  = AcqSig_i && (r_wdt_cnt == WW'(WDT_TICKS - 1));

    always_comb begin
        w_next         = r_state;
        RxCoreEnable_o = 1'b0;
        RxCoreRst_o    = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (p_Enable_i) w_next = S_ARMED;
            end
            S_ARMED: begin
                RxCoreEnable_o = 1'b1;
                if (!w_interval) w_next = S_RECEIVING;
            end
            S_RECEIVING: begin
                RxCoreEnable_o = 1'b1;
                if (!w_onehot || w_wdt_hit) w_next = S_RECOVER;
                else if (w_interval)        w_next = S_ARMED;
            end
            S_RECOVER: begin
                RxCoreRst_o = 1'b0;
                if (r_rcv_cnt == RW'(RCV_CYC - 1)) w_next = S_ARMED;
            end
            default: w_next = S_IDLE;
        endcase
        if (!p_Enable_i) w_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_wdt_cnt <= '0;
            r_rcv_cnt <= '0;
            r_wdt_evt <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_wdt_evt <= (w_next == S_RECOVER) && (r_state != S_RECOVER);
            if (r_state != S_RECEIVING) r_wdt_cnt <= '0;
            else if (AcqSig_i)          r_wdt_cnt <= r_wdt_cnt + WW'(1);
            if (r_state == S_RECOVER) r_rcv_cnt <= r_rcv_cnt + RW'(1);
            else                      r_rcv_cnt <= '0;
        end
    end

    assign WdtEvent_o = r_wdt_evt;

    // A byte arriving on the gap-closing tick wins: the marker is dropped and the gap restarts.
    assign w_gap_hit    = (r_state == S_ARMED) && w_interval && AcqSig_i &&
                          (r_gap_cnt == GW'(GAP_TICKS - 1));
    assign w_byte_push  = ByteValid_i && ((r_state == S_ARMED) || (r_state == S_RECEIVING));
    assign w_mark_push  = w_gap_hit && r_byte_since_marker && !ByteValid_i;
    assign w_push       = w_byte_push || w_mark_push;
    assign w_push_entry = w_byte_push ? {1'b0, ParityErr_i | StopErr_i, ByteData_i}
                                      : {1'b1, 1'b0, 8'h00};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_gap_cnt           <= '0;
            r_byte_since_marker <= 1'b0;
        end else begin
            if (((w_next == S_ARMED) && (r_state != S_ARMED)) || ByteValid_i)
                r_gap_cnt <= '0;
            else if ((r_state == S_ARMED) && w_interval && AcqSig_i &&
                     (r_gap_cnt != GW'(GAP_TICKS)))
                r_gap_cnt <= r_gap_cnt + GW'(1);
            if (w_byte_push)      r_byte_since_marker <= 1'b1;
            else if (w_mark_push) r_byte_since_marker <= 1'b0;
        end
    end

    assign w_valid = (r_count != '0);
    assign w_full  = (r_count == CNT_FULL);
    assign w_pop   = w_valid && host.Ready_i;
    assign w_wr    = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= w_push_entry;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_push && !w_wr)    r_overflow <= 1'b1;
            else if (OverflowClr_i) r_overflow <= 1'b0;
        end
    end

    assign host.Valid_o  = w_valid;
    assign host.Count_o  = r_count;
    assign host.Marker_o = r_mem[r_rd_ptr][9];
    assign host.Err_o    = r_mem[r_rd_ptr][8];
    assign host.Data_o   = r_mem[r_rd_ptr][7:0];
    assign Overflow_o    = r_overflow;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: vector table for the byte path, hand sequences for gap,
// watchdog, overflow, enable and reset corners.
module tb_uart_rx_ctrl;

    localparam logic [4:0] ST_INT   = 5'b00001;
    localparam logic [4:0] ST_START = 5'b00010;
    localparam logic [4:0] ST_DATA  = 5'b00100;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, acq, bv, perr, serr, rdy, oclr;
    logic [4:0] st;
    logic [7:0] bd;
    logic       core_en, core_rst, ovf, wdt;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    uart_rx_ctrl_if #(.AW(3)) host ();
    assign host.Ready_i = rdy;

    uart_rx_ctrl #(
        .DEPTH(8), .AW(3), .WDT_TICKS(240), .GAP_TICKS(48), .RCV_CYC(4)
    ) dut (
        .clk(clk), .rst(rst), .p_Enable_i(en), .AcqSig_i(acq), .RxState_i(st),
        .ByteValid_i(bv), .ByteData_i(bd), .ParityErr_i(perr), .StopErr_i(serr),
        .RxCoreEnable_o(core_en), .RxCoreRst_o(core_rst), .host(host),
        .Overflow_o(ovf), .OverflowClr_i(oclr), .WdtEvent_o(wdt)
    );

    typedef struct {
        logic        en, acq;
        logic [4:0]  st;
        logic        bv;
        logic [7:0]  bd;
        logic        perr, serr, rdy, oclr;
        logic [18:0] exp;
    } vec_t;

    vec_t tbl[8];

    function automatic logic [18:0] mk(input logic e_en, input logic e_rst, input logic e_wdt,
                                       input logic e_v, input logic e_m, input logic e_e,
                                       input logic [7:0] e_d, input logic [3:0] e_c,
                                       input logic e_o);
        return {e_en, e_rst, e_wdt, e_v, e_m, e_e, e_d, e_c, e_o};
    endfunction

    function automatic logic [18:0] obs();
        return {core_en, core_rst, wdt, host.Valid_o, host.Marker_o, host.Err_o,
                host.Data_o, host.Count_o, ovf};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Head-entry fields are only meaningful while Valid_o is expected high.
    task automatic chk_vec(input string name, input logic [18:0] exp);
        logic [18:0] act;
        logic [18:0] m;
        act = obs();
        m   = exp[15] ? 19'h7FFFF : ~19'h07FE0;
        n_total++;
        if ((act & m) === (exp & m)) n_pass++;
        else $display("FAIL %s: got {en,rst,wdt,v,m,e,d,cnt,ovf}=%05h expected %05h",
                      name, act & m, exp & m);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic idle_in();
        acq = 1'b0; bv = 1'b0; bd = 8'h00; perr = 1'b0; serr = 1'b0; rdy = 1'b0; oclr = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            acq = 1'b1; step();
            acq = 1'b0; step();
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; st = ST_INT;
        idle_in();
        step(); step();
        chk_vec("reset", mk(0, 1, 0, 0, 0, 0, 8'h00, 4'd0, 0));
        rst = 1'b1;

        tbl[0] = '{1'b1, 1'b0, ST_INT,   1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, mk(1, 1, 0, 0, 0, 0, 8'h00, 4'd0, 0)};
        tbl[1] = '{1'b1, 1'b0, ST_START, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, mk(1, 1, 0, 0, 0, 0, 8'h00, 4'd0, 0)};
        tbl[2] = '{1'b1, 1'b0, ST_DATA,  1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, mk(1, 1, 0, 1, 0, 0, 8'h55, 4'd1, 0)};
        tbl[3] = '{1'b1, 1'b0, ST_DATA,  1'b1, 8'hA3, 1'b1, 1'b0, 1'b0, 1'b0, mk(1, 1, 0, 1, 0, 0, 8'h55, 4'd2, 0)};
        tbl[4] = '{1'b1, 1'b0, ST_INT,   1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, mk(1, 1, 0, 1, 0, 1, 8'hA3, 4'd1, 0)};
        tbl[5] = '{1'b1, 1'b0, ST_INT,   1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, mk(1, 1, 0, 0, 0, 0, 8'h00, 4'd0, 0)};
        tbl[6] = '{1'b1, 1'b0, ST_INT,   1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, mk(1, 1, 0, 1, 0, 1, 8'h3C, 4'd1, 0)};
        tbl[7] = '{1'b1, 1'b0, ST_INT,   1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, mk(1, 1, 0, 0, 0, 0, 8'h00, 4'd0, 0)};

        for (int unsigned i = 0; i < 8; i++) begin
            en = tbl[i].en; acq = tbl[i].acq; st = tbl[i].st; bv = tbl[i].bv; bd = tbl[i].bd;
            perr = tbl[i].perr; serr = tbl[i].serr; rdy = tbl[i].rdy; oclr = tbl[i].oclr;
            step();
            chk_vec($sformatf("vec%0d", i), tbl[i].exp);
        end
        idle_in(); st = ST_INT;

        // Frame-end marker after an idle gap, and only one per gap
        bv = 1'b1; bd = 8'h12; step(); bv = 1'b0;
        chk_vec("byte_12", mk(1, 1, 0, 1, 0, 0, 8'h12, 4'd1, 0));
        ticks(47);
        chk("gap_47_no_marker", host.Count_o, 1);
        ticks(1);
        chk("gap_48_marker", host.Count_o, 2);
        rdy = 1'b1; step(); rdy = 1'b0;
        chk_vec("marker_head", mk(1, 1, 0, 1, 1, 0, 8'h00, 4'd1, 0));
        ticks(100);
        chk("no_second_marker", host.Count_o, 1);

        // Watchdog on a stuck DATABITS state
        st = ST_DATA; step();
        chk_vec("receiving", mk(1, 1, 0, 1, 1, 0, 8'h00, 4'd1, 0));
        ticks(239);
        chk_vec("wdt_239", mk(1, 1, 0, 1, 1, 0, 8'h00, 4'd1, 0));
        acq = 1'b1; step(); acq = 1'b0;
        chk_vec("wdt_entry", mk(0, 0, 1, 1, 1, 0, 8'h00, 4'd1, 0));
        st = ST_INT; bv = 1'b1; bd = 8'hEE; step(); bv = 1'b0;
        chk_vec("recover_c2_byte_ignored", mk(0, 0, 0, 1, 1, 0, 8'h00, 4'd1, 0));
        step(); step();
        chk_vec("recover_c4", mk(0, 0, 0, 1, 1, 0, 8'h00, 4'd1, 0));
        step();
        chk_vec("recover_exit", mk(1, 1, 0, 1, 1, 0, 8'h00, 4'd1, 0));

        // Non-one-hot core state forces recovery
        st = ST_START; step();
        chk("invalid_pre_en", core_en, 1);
        st = 5'b00110; step();
        chk_vec("invalid_onehot", mk(0, 0, 1, 1, 1, 0, 8'h00, 4'd1, 0));
        st = ST_INT; step(); step(); step();
        chk("invalid_c4_rst", core_rst, 0);
        step();
        chk_vec("invalid_exit", mk(1, 1, 0, 1, 1, 0, 8'h00, 4'd1, 0));
        rdy = 1'b1; step(); rdy = 1'b0;
        chk("marker_popped", host.Count_o, 0);

        // Overflow, full push+pop, set-over-clear priority, wrapped drain
        for (int unsigned i = 1; i <= 9; i++) begin
            bv = 1'b1; bd = 8'(i); step();
            if (i == 8) chk_vec("fill_8", mk(1, 1, 0, 1, 0, 0, 8'h01, 4'd8, 0));
        end
        bv = 1'b0;
        chk_vec("ovf_full", mk(1, 1, 0, 1, 0, 0, 8'h01, 4'd8, 1));
        oclr = 1'b1; step(); oclr = 1'b0;
        chk_vec("ovf_clear", mk(1, 1, 0, 1, 0, 0, 8'h01, 4'd8, 0));
        bv = 1'b1; bd = 8'hA0; rdy = 1'b1; step(); bv = 1'b0; rdy = 1'b0;
        chk_vec("full_push_pop", mk(1, 1, 0, 1, 0, 0, 8'h02, 4'd8, 0));
        bv = 1'b1; bd = 8'hBB; oclr = 1'b1; step(); bv = 1'b0; oclr = 1'b0;
        chk_vec("ovf_set_prio", mk(1, 1, 0, 1, 0, 0, 8'h02, 4'd8, 1));
        oclr = 1'b1; step(); oclr = 1'b0;
        chk("ovf_clear2", ovf, 0);
        rdy = 1'b1;
        for (int unsigned k = 1; k <= 8; k++) begin
            logic [7:0] e;
            step();
            e = (k <= 6) ? 8'(2 + k) : 8'hA0;
            chk_vec($sformatf("drain%0d", k), mk(1, 1, 0, (k < 8), 0, 0, e, 4'(8 - k), 0));
        end
        rdy = 1'b0;

        // Byte on the gap-closing tick drops the marker and restarts the gap
        ticks(47);
        acq = 1'b1; bv = 1'b1; bd = 8'h99; step(); acq = 1'b0; bv = 1'b0; step();
        chk_vec("collision_byte", mk(1, 1, 0, 1, 0, 0, 8'h99, 4'd1, 0));
        ticks(47);
        chk("collision_gap_47", host.Count_o, 1);
        ticks(1);
        chk("collision_marker", host.Count_o, 2);
        rdy = 1'b1; step();
        chk_vec("collision_head_marker", mk(1, 1, 0, 1, 1, 0, 8'h00, 4'd1, 0));
        step(); rdy = 1'b0;
        chk("collision_drained", host.Count_o, 0);

        // Enable dropped mid-reception
        st = ST_START; step();
        chk("en_receiving", core_en, 1);
        en = 1'b0; step();
        chk_vec("enable_drop", mk(0, 1, 0, 0, 0, 0, 8'h00, 4'd0, 0));
        bv = 1'b1; bd = 8'h44; step(); bv = 1'b0;
        chk("idle_byte_ignored", host.Count_o, 0);

        // Reset mid-frame
        st = ST_INT; en = 1'b1; step();
        st = ST_DATA; step();
        bv = 1'b1; bd = 8'h5A; step(); bv = 1'b0;
        chk_vec("pre_reset_byte", mk(1, 1, 0, 1, 0, 0, 8'h5A, 4'd1, 0));
        rst = 1'b0; step();
        chk_vec("reset_midframe", mk(0, 1, 0, 0, 0, 0, 8'h00, 4'd0, 0));
        rst = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Sequencing controller for the UART receive core. It enables the Rx core and watches its one-hot state output with a watchdog. On a stall it force-restarts the core. It buffers received bytes with their error flags in a small show-ahead FIFO and inserts a frame-end marker after an idle line gap. It sits between the Rx core and the host/register interface.

Parameters:
DEPTH, 8, FIFO entries (power of 2, >=2)
AW, 3, log2(DEPTH)
WDT_TICKS, 240, AcqSig_i ticks allowed in one non-INTERVAL episode before recovery (11 bits x 16 + margin)
GAP_TICKS, 48, AcqSig_i ticks of continuous INTERVAL that close a frame (3 bit times)
RCV_CYC, 4, clk cycles RxCoreRst_o is held low during recovery

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
p_Enable_i  in  1  controller enable
AcqSig_i  in  1  16x-baud acquisition tick, one clk wide
RxState_i  in  5  Rx core state, one-hot: INTERVAL=00001, STARTBIT=00010, DATABITS=00100, PARITYBIT=01000, STOPBIT=10000
ByteValid_i  in  1  one-clk pulse, received byte available
ByteData_i  in  8  received byte
ParityErr_i  in  1  parity error for byte, qualified by ByteValid_i
StopErr_i  in  1  stop-bit error for byte, qualified by ByteValid_i
RxCoreEnable_o  out  1  enable to Rx core
RxCoreRst_o  out  1  active-low restart to Rx core
Valid_o  out  1  FIFO head valid
Data_o  out  8  head byte (0 for marker)
Err_o  out  1  head byte had parity or stop error
Marker_o  out  1  head entry is a frame-end marker
Ready_i  in  1  consumer accepts head when Valid_o=1
Count_o  out  AW+1  FIFO occupancy, 0..DEPTH
Overflow_o  out  1  sticky: a push was dropped
OverflowClr_i  in  1  clears Overflow_o
WdtEvent_o  out  1  one-clk pulse on watchdog recovery entry

Behaviour:
- Single clock domain; one clock, reset synchronous active-low on rst. On rst=0: FSM=IDLE, FIFO empty, Valid_o=0, Count_o=0, Overflow_o=0, RxCoreEnable_o=0, RxCoreRst_o=1, WdtEvent_o=0, wdt/gap counters=0, byte_since_marker=0.
- FSM states: IDLE, ARMED, RECEIVING, RECOVER.
- Enable: p_Enable_i=0 in any state -> IDLE next cycle; RxCoreRst_o returns to 1.
- IDLE: RxCoreEnable_o=0. p_Enable_i=1 -> ARMED.
- ARMED: RxCoreEnable_o=1. RxState_i!=INTERVAL -> RECEIVING with wdt counter=0.
- RECEIVING: RxCoreEnable_o=1. wdt counter increments on AcqSig_i. If the count reaches WDT_TICKS, or RxState_i is not one-hot (zero or multi-bit) -> RECOVER. RxState_i==INTERVAL -> ARMED.
- RECOVER: entry pulses WdtEvent_o for 1 cycle. RxCoreRst_o=0 and RxCoreEnable_o=0 for exactly RCV_CYC cycles, then ARMED. A partial byte is discarded; no marker is inserted.
- Gap detection, ARMED only: gap counter increments on AcqSig_i while RxState_i==INTERVAL. It clears on entering ARMED and on any ByteValid_i. When the counter reaches GAP_TICKS with byte_since_marker=1, push a marker entry {marker=1, err=0, data=0} and clear byte_since_marker. At most one marker per gap.
- Byte push: ByteValid_i=1 in ARMED or RECEIVING pushes {marker=0, err=ParityErr_i|StopErr_i, data=ByteData_i} and sets byte_since_marker. Ignored in IDLE and RECOVER.
- Byte and marker in the same cycle: the byte is pushed, the marker is dropped, and the gap counter restarts.
- FIFO is show-ahead: Valid_o=(Count_o!=0). Data_o, Err_o and Marker_o come from the head entry. A pop occurs when Valid_o&Ready_i. Pointers are AW bits and wrap modulo DEPTH.
- Push when full: the entry is dropped, Overflow_o=1 next cycle. Exception: a simultaneous pop makes the push succeed with Count_o unchanged.
- Push and pop when empty: the push is stored and the pop is ignored because Valid_o=0.
- Count_o updates the cycle after push/pop: +1, -1, or unchanged for both.
- Overflow_o: set has priority over OverflowClr_i in the same cycle.
- FIFO contents persist through IDLE and RECOVER; only rst flushes them.

Test Plan:
- Reset then p_Enable_i=1; feed bytes 0x55 then 0xA3 (ParityErr_i=1) -> Valid_o=1, head 0x55/Err 0, pop -> 0xA3/Err 1, Count_o 2->1->0.
- After byte 0x12, RxState_i=INTERVAL for 48 AcqSig_i ticks -> marker entry pushed (Marker_o=1, Data_o=0). Holding a further 100 ticks -> no second marker.
- RxState_i=DATABITS held for 240 AcqSig_i ticks -> WdtEvent_o 1-cycle pulse, RxCoreRst_o=0 for 4 cycles, then ARMED; FIFO unchanged.
- RxState_i=5'b00110 while RECEIVING -> RECOVER next cycle.
- Ready_i=0, push 9 bytes with DEPTH=8 -> Count_o=8, Overflow_o=1, head is byte 1. With FIFO full, push and Ready_i=1 in the same cycle -> Count_o stays 8, Overflow_o not newly set. OverflowClr_i -> 0.
- p_Enable_i dropped mid-RECEIVING -> IDLE next cycle, RxCoreEnable_o=0, later ByteValid_i ignored. rst=0 mid-frame -> all outputs at reset values on the next clk edge.
